// File: rtl/instr_cache_sa.sv
// rtl/instr_cache_sa.sv - N-way set-associative instruction cache with round-robin replacement
module instr_cache_sa #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int N_SETS     = 4,
    parameter int N_WAYS     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [1:0]              cpu_size,
    input  logic                    cpu_flush,
    output logic                    cpu_ready,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_rvalid,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [LINE_BYTES*8-1:0] mem_rdata,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(N_SETS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t state;

    logic              valid_q [N_SETS][N_WAYS];
    logic [TAG_W-1:0]  tag_q   [N_SETS][N_WAYS];
    logic [LINE_W-1:0] data_q  [N_SETS][N_WAYS];
    logic [WAY_W-1:0]  rr_q    [N_SETS];
    logic              flush_pend;

    logic [ADDR_WIDTH-1:0] miss_addr;
    logic [1:0]            miss_size;
    logic [WAY_W-1:0]      miss_way;
    logic                  miss_rr;

    logic [IDX_W-1:0] idx, miss_idx;
    logic [TAG_W-1:0] tag;
    logic             hit, vic_rr;
    logic [WAY_W-1:0] hit_way, vic_way;

    assign idx       = cpu_addr[OFF_W +: IDX_W];
    assign tag       = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign miss_idx  = miss_addr[OFF_W +: IDX_W];
    assign cpu_ready = (state == S_IDLE) && !cpu_flush;

    function automatic logic [31:0] extract(input logic [LINE_W-1:0] line,
                                            input logic [OFF_W-1:0]  off,
                                            input logic [1:0]        size);
        logic [31:0] word;
        logic [31:0] byte_sh;
        word    = 32'(line >> (32 * int'(off >> 2)));
        byte_sh = word >> {off[1:0], 3'b000};
        case (size)
            2'b00:   extract = {24'b0, byte_sh[7:0]};
            2'b01:   extract = off[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
            default: extract = word;
        endcase
    endfunction

    // Victim is the lowest invalid way; only a full set falls back to the round-robin pointer.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_way = rr_q[idx];
        vic_rr  = 1'b1;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                vic_way = WAY_W'(w);
                vic_rr  = 1'b0;
            end
        end
        for (int w = 0; w < N_WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            flush_pend <= 1'b0;
            miss_addr  <= '0;
            miss_size  <= '0;
            miss_way   <= '0;
            miss_rr    <= 1'b0;
            for (int s = 0; s < N_SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < N_WAYS; w++) valid_q[s][w] <= 1'b0;
            end
        end else begin
            cpu_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_flush) begin
                        for (int s = 0; s < N_SETS; s++) begin
                            rr_q[s] <= '0;
                            for (int w = 0; w < N_WAYS; w++) valid_q[s][w] <= 1'b0;
                        end
                    end else if (cpu_req) begin
                        if (hit) begin
                            cpu_rvalid <= 1'b1;
                            cpu_rdata  <= extract(data_q[idx][hit_way], cpu_addr[OFF_W-1:0], cpu_size);
                            if (hit_count != '1) hit_count <= hit_count + 32'd1;
                        end else begin
                            miss_addr <= cpu_addr;
                            miss_size <= cpu_size;
                            miss_way  <= vic_way;
                            miss_rr   <= vic_rr;
                            mem_addr  <= {cpu_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                            mem_req   <= 1'b1;
                            state     <= S_REQ;
                            if (miss_count != '1) miss_count <= miss_count + 32'd1;
                        end
                    end
                end
                S_REQ: begin
                    if (cpu_flush) flush_pend <= 1'b1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cpu_flush) flush_pend <= 1'b1;
                    if (mem_rvalid) begin
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= extract(mem_rdata, miss_addr[OFF_W-1:0], miss_size);
                        state      <= S_IDLE;
                        // A flush seen during the refill wins over installing the fetched line.
                        if (flush_pend || cpu_flush) begin
                            flush_pend <= 1'b0;
                            for (int s = 0; s < N_SETS; s++) begin
                                rr_q[s] <= '0;
                                for (int w = 0; w < N_WAYS; w++) valid_q[s][w] <= 1'b0;
                            end
                        end else begin
                            valid_q[miss_idx][miss_way] <= 1'b1;
                            tag_q[miss_idx][miss_way]   <= miss_addr[ADDR_WIDTH-1 -: TAG_W];
                            data_q[miss_idx][miss_way]  <= mem_rdata;
                            if (miss_rr)
                                rr_q[miss_idx] <= (N_WAYS == 1) ? '0 : rr_q[miss_idx] + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_cache_sa.sv
// tb/tb_instr_cache_sa.sv - directed bench with a line-level cache model for instr_cache_sa
module tb_instr_cache_sa;
    logic         clk = 1'b0;
    logic         rst, cpu_req, cpu_flush, mem_gnt, mem_rvalid;
    logic [31:0]  cpu_addr;
    logic [1:0]   cpu_size;
    logic [127:0] mem_rdata;
    logic         cpu_ready, cpu_rvalid, mem_req;
    logic [31:0]  cpu_rdata, mem_addr, hit_count, miss_count;

    always #5 clk = ~clk;

    instr_cache_sa #(.ADDR_WIDTH(32), .LINE_BYTES(16), .N_SETS(4), .N_WAYS(2)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
        .cpu_flush(cpu_flush), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic        e_rvalid = 1'b0, e_mreq = 1'b0, m_idle = 1'b1;
    logic [31:0] e_rdata = '0, e_maddr = '0, e_hit = '0, e_miss = '0;

    bit [31:0] wmem [int unsigned];
    bit        m_valid [4][2];
    bit [31:0] m_line  [4][2];
    int        m_rr    [4];
    bit        m_pend = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit [31:0] word_at(bit [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] expect_data(bit [31:0] a, logic [1:0] sz);
        bit [31:0] w;
        w = word_at(a & ~32'h3);
        case (sz)
            2'b00:   return (w >> (8 * a[1:0])) & 32'hFF;
            2'b01:   return a[1] ? (w >> 16) : (w & 32'hFFFF);
            default: return w;
        endcase
    endfunction

    function automatic logic [127:0] line_of(bit [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = word_at((a & ~32'hF) + 32'(4 * i));
        return l;
    endfunction

    function automatic void flush_model();
        for (int s = 0; s < 4; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rvalid", cpu_rvalid, e_rvalid);
            if (e_rvalid) chk("rdata", cpu_rdata, e_rdata);
            chk("ready", cpu_ready, m_idle && !cpu_flush);
            chk("mem_req", mem_req, e_mreq);
            if (e_mreq) chk("mem_addr", mem_addr, e_maddr);
            chk("hit_count", hit_count, e_hit);
            chk("miss_count", miss_count, e_miss);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        e_rvalid = 1'b0;
    endtask

    task automatic fetch(input bit [31:0] a, input logic [1:0] sz, input int gnt_dly = 0,
                         input int rv_dly = 0, input bit flush_wait = 1'b0);
        int s, v;
        bit h, used_rr;
        s = int'((a >> 4) % 4);
        h = 1'b0;
        for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_line[s][w] == (a >> 4)) h = 1'b1;
        cpu_req = 1'b1; cpu_addr = a; cpu_size = sz;
        step();
        cpu_req = 1'b0;
        if (h) begin
            e_rvalid = 1'b1;
            e_rdata  = expect_data(a, sz);
            if (e_hit != '1) e_hit++;
            return;
        end
        v = -1;
        for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        used_rr = (v < 0);
        if (used_rr) v = m_rr[s];
        if (e_miss != '1) e_miss++;
        e_mreq = 1'b1; e_maddr = a & ~32'hF; m_idle = 1'b0;
        repeat (gnt_dly) step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; e_mreq = 1'b0;
        if (flush_wait) begin cpu_flush = 1'b1; m_pend = 1'b1; end
        for (int i = 0; i < rv_dly; i++) begin step(); cpu_flush = 1'b0; end
        mem_rvalid = 1'b1; mem_rdata = line_of(a);
        step();
        mem_rvalid = 1'b0; cpu_flush = 1'b0;
        e_rvalid = 1'b1; e_rdata = expect_data(a, sz); m_idle = 1'b1;
        if (m_pend) begin
            flush_model();
            m_pend = 1'b0;
        end else begin
            m_valid[s][v] = 1'b1;
            m_line[s][v]  = a >> 4;
            if (used_rr) m_rr[s] = (m_rr[s] + 1) % 2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m0;
        rst = 1'b1; cpu_req = 1'b0; cpu_flush = 1'b0; cpu_addr = '0; cpu_size = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        wmem[32'h104] = 32'hDEADBEEF;
        wmem[32'h200] = 32'h11223344;
        flush_model();
        step(); step();
        chk_en = 1'b1;
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        // cold miss then hit
        fetch(32'h100, 2'b10);
        chk("cold_word0", cpu_rdata, 32'hFEFF0100);
        fetch(32'h104, 2'b10);
        chk("hit_word1", cpu_rdata, 32'hDEADBEEF);
        chk("cold_hits", hit_count, 32'd1);
        chk("cold_misses", miss_count, 32'd1);

        // associativity and round-robin eviction in set 0
        fetch(32'h140, 2'b10);
        fetch(32'h100, 2'b10);
        fetch(32'h140, 2'b10);
        fetch(32'h180, 2'b10);
        fetch(32'h100, 2'b10);
        chk("rr_misses", miss_count, 32'd4);
        chk("rr_hits", hit_count, 32'd3);

        // sub-word extraction
        fetch(32'h201, 2'b00);
        chk("byte_201", cpu_rdata, 32'h33);
        fetch(32'h203, 2'b00);
        chk("byte_203", cpu_rdata, 32'h11);
        fetch(32'h202, 2'b01);
        chk("half_202", cpu_rdata, 32'h1122);
        fetch(32'h200, 2'b01);
        chk("half_200", cpu_rdata, 32'h3344);
        fetch(32'h20C, 2'b11);

        // grant stall
        fetch(32'h300, 2'b10, 5, 2);

        // flush in idle, concurrent request refused
        cpu_flush = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h300; cpu_size = 2'b10;
        step();
        cpu_flush = 1'b0; cpu_req = 1'b0;
        flush_model();
        m0 = miss_count;
        fetch(32'h300, 2'b10);
        chk("flush_idle_remiss", miss_count, m0 + 32'd1);

        // flush during refill: data returned, line not kept
        fetch(32'h340, 2'b10, 1, 2, 1'b1);
        m0 = miss_count;
        fetch(32'h340, 2'b10);
        chk("flush_wait_remiss", miss_count, m0 + 32'd1);
        fetch(32'h344, 2'b10);
        fetch(32'h348, 2'b00);

        // reset during refill
        cpu_req = 1'b1; cpu_addr = 32'h400; cpu_size = 2'b10;
        step();
        cpu_req = 1'b0; e_mreq = 1'b1; e_maddr = 32'h400; e_miss++; m_idle = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; e_mreq = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; e_hit = '0; e_miss = '0; m_idle = 1'b1; m_pend = 1'b0;
        flush_model();
        chk("rst_mid_mem_req", mem_req, 32'd0);
        chk("rst_mid_ready", cpu_ready, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = line_of(32'h400);
        step();
        mem_rvalid = 1'b0;
        chk("late_rvalid", cpu_rvalid, 32'd0);
        chk("rst_mid_hits", hit_count, 32'd0);
        chk("rst_mid_misses", miss_count, 32'd0);
        fetch(32'h400, 2'b10);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
